// File: rtl/binary_to_gray_pkg.sv
// -----------------------------------------------------------------------------
// binary_to_gray_pkg
// Shared definitions for the binary/Gray conversion blocks.
//   GRAY_W   : fixed code width (4 bits)
//   bin2gray : binary -> reflected Gray code
//   gray2bin : reflected Gray code -> binary
// -----------------------------------------------------------------------------
package binary_to_gray_pkg;

  localparam int GRAY_W = 4;

  typedef logic [GRAY_W-1:0] word_t;

  // Each Gray bit is the XOR of a binary bit with its more-significant neighbour.
  function automatic word_t bin2gray(input word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic word_t gray2bin(input word_t gray);
    word_t bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_to_binary.sv
// -----------------------------------------------------------------------------
// gray_to_binary
// Purely combinational reflected-Gray to binary decoder.
//   gray : input  [GRAY_W-1:0]  Gray-coded word (MSB first)
//   bin  : output [GRAY_W-1:0]  decoded binary word
// -----------------------------------------------------------------------------
module gray_to_binary
  import binary_to_gray_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [GRAY_W-1:0] bin
);

  // Binary bit i is the reduction XOR of Gray bits GRAY_W-1 down to i.
  // Written as a prefix reduction rather than a chain on bin[] so that no
  // vector bit depends on another bit of the same vector.
  for (genvar gi = 0; gi < GRAY_W; gi++) begin : g_bit
    assign bin[gi] = ^gray[GRAY_W-1:gi];
  end

endmodule

// File: rtl/binary_to_gray.sv
// -----------------------------------------------------------------------------
// binary_to_gray
// 4-bit binary to reflected Gray converter with a registered output stage and
// a sticky round-trip self-check.
//   clk       : in   rising-edge clock
//   rst_n     : in   synchronous reset, active-low
//   in_valid  : in   a/b/c/d carry a valid word this cycle
//   a,b,c,d   : in   binary word, a = MSB, d = LSB
//   out_valid : out  w/x/y/z hold a freshly converted word (1-cycle latency)
//   w,x,y,z   : out  Gray word, w = MSB, z = LSB
//   rt_err    : out  sticky flag: decoded Gray word did not match the input
// -----------------------------------------------------------------------------
module binary_to_gray
  import binary_to_gray_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic out_valid,
  output logic w,
  output logic x,
  output logic y,
  output logic z,
  output logic rt_err
);

  word_t bin_in;
  word_t gray_reg;
  word_t bin_reg;       // copy of the binary word that produced gray_reg
  word_t rt_decoded;    // gray_reg decoded back to binary
  logic  out_valid_reg;
  logic  rt_err_reg;

  assign bin_in = {a, b, c, d};

  gray_to_binary u_checker (
    .gray (gray_reg),
    .bin  (rt_decoded)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_reg      <= '0;
      bin_reg       <= '0;
      out_valid_reg <= 1'b0;
      rt_err_reg    <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      // Data registers only load on a valid word, so outputs hold otherwise
      // and an X on a/b/c/d while idle never reaches them.
      if (in_valid) begin
        gray_reg <= bin2gray(bin_in);
        bin_reg  <= bin_in;
      end
      // Compare the word currently on the outputs; the flag is sticky.
      if (out_valid_reg && (rt_decoded != bin_reg)) begin
        rt_err_reg <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign w         = gray_reg[3];
  assign x         = gray_reg[2];
  assign y         = gray_reg[1];
  assign z         = gray_reg[0];
  assign rt_err    = rt_err_reg;

endmodule

// File: tb/tb_binary_to_gray.sv
// -----------------------------------------------------------------------------
// tb_binary_to_gray
// Directed self-checking bench for binary_to_gray. Inputs change 1 ns after a
// rising edge; outputs are sampled at the same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_binary_to_gray;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic a, b, c, d;
  logic out_valid;
  logic w, x, y, z;
  logic rt_err;

  int tests  = 0;
  int failed = 0;

  logic [3:0] wxyz;
  assign wxyz = {w, x, y, z};

  always #5 clk = ~clk;

  binary_to_gray dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .w         (w),
    .x         (x),
    .y         (y),
    .z         (z),
    .rt_err    (rt_err)
  );

  // Advance one clock; returns 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] abcd);
    in_valid = v;
    {a, b, c, d} = abcd;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'b1111);
    for (int i = 0; i < 2; i++) begin
      step();
      $display("[TB] reset cycle %0d: wxyz=%b out_valid=%b rt_err=%b", i, wxyz, out_valid, rt_err);
      tests++;
      if (wxyz !== 4'b0000) begin
        failed++;
        $display("FAIL reset_wxyz cycle %0d: got %b expected 0000", i, wxyz);
      end
      tests++;
      if (out_valid !== 1'b0) begin
        failed++;
        $display("FAIL reset_out_valid cycle %0d: got %b expected 0", i, out_valid);
      end
      tests++;
      if (rt_err !== 1'b0) begin
        failed++;
        $display("FAIL reset_rt_err cycle %0d: got %b expected 0", i, rt_err);
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 4'b0000);
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single();
    logic [3:0] bin_vec  [4] = '{4'b0000, 4'b0101, 4'b1010, 4'b1111};
    logic [3:0] gray_vec [4] = '{4'b0000, 4'b0111, 4'b1111, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, bin_vec[i]);
      step();
      $display("[TB] single abcd=%b -> wxyz=%b out_valid=%b", bin_vec[i], wxyz, out_valid);
      tests++;
      if (wxyz !== gray_vec[i]) begin
        failed++;
        $display("FAIL single_wxyz abcd=%b: got %b expected %b", bin_vec[i], wxyz, gray_vec[i]);
      end
      tests++;
      if (out_valid !== 1'b1) begin
        failed++;
        $display("FAIL single_out_valid abcd=%b: got %b expected 1", bin_vec[i], out_valid);
      end
      drive(1'b0, 4'b0000);
      step();
      tests++;
      if (out_valid !== 1'b0) begin
        failed++;
        $display("FAIL single_out_valid_drop abcd=%b: got %b expected 0", bin_vec[i], out_valid);
      end
      tests++;
      if (wxyz !== gray_vec[i]) begin
        failed++;
        $display("FAIL single_hold abcd=%b: got %b expected %b", bin_vec[i], wxyz, gray_vec[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_sweep();
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                  4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] prev;
    // 17 words: 0..15 then wrap back to 0.
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] bin;
      logic [3:0] expv;
      bin  = 4'(i % 16);
      expv = gray_tab[i % 16];
      drive(1'b1, bin);
      step();
      $display("[TB] sweep abcd=%b -> wxyz=%b", bin, wxyz);
      tests++;
      if (wxyz !== expv) begin
        failed++;
        $display("FAIL sweep_wxyz abcd=%b: got %b expected %b", bin, wxyz, expv);
      end
      if (i > 0) begin
        tests++;
        if ($countones(wxyz ^ prev) != 1) begin
          failed++;
          $display("FAIL sweep_one_bit %b->%b: got %0d bit changes expected 1", prev, wxyz, $countones(wxyz ^ prev));
        end
      end
      tests++;
      if (out_valid !== 1'b1) begin
        failed++;
        $display("FAIL sweep_out_valid abcd=%b: got %b expected 1", bin, out_valid);
      end
      tests++;
      if (rt_err !== 1'b0) begin
        failed++;
        $display("FAIL sweep_rt_err abcd=%b: got %b expected 0", bin, rt_err);
      end
      prev = wxyz;
    end
    drive(1'b0, 4'b0000);
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_hold();
    drive(1'b1, 4'b0110);
    step();
    $display("[TB] hold load abcd=0110 -> wxyz=%b", wxyz);
    tests++;
    if (wxyz !== 4'b0101) begin
      failed++;
      $display("FAIL hold_load: got %b expected 0101", wxyz);
    end
    drive(1'b0, 4'b1001);
    for (int i = 0; i < 3; i++) begin
      step();
      $display("[TB] hold idle %0d: wxyz=%b out_valid=%b", i, wxyz, out_valid);
      tests++;
      if (wxyz !== 4'b0101) begin
        failed++;
        $display("FAIL hold_wxyz cycle %0d: got %b expected 0101", i, wxyz);
      end
      tests++;
      if (out_valid !== 1'b0) begin
        failed++;
        $display("FAIL hold_out_valid cycle %0d: got %b expected 0", i, out_valid);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_midstream_reset();
    drive(1'b1, 4'b0011);
    step();
    $display("[TB] stream abcd=0011 -> wxyz=%b", wxyz);
    tests++;
    if (wxyz !== 4'b0010) begin
      failed++;
      $display("FAIL stream_0011: got %b expected 0010", wxyz);
    end
    drive(1'b1, 4'b0100);
    step();
    $display("[TB] stream abcd=0100 -> wxyz=%b", wxyz);
    tests++;
    if (wxyz !== 4'b0110) begin
      failed++;
      $display("FAIL stream_0100: got %b expected 0110", wxyz);
    end
    rst_n = 1'b0;
    drive(1'b1, 4'b0101);
    step();
    $display("[TB] stream reset with abcd=0101 -> wxyz=%b out_valid=%b", wxyz, out_valid);
    tests++;
    if (wxyz !== 4'b0000) begin
      failed++;
      $display("FAIL midreset_wxyz: got %b expected 0000", wxyz);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      failed++;
      $display("FAIL midreset_out_valid: got %b expected 0", out_valid);
    end
    rst_n = 1'b1;
    drive(1'b1, 4'b0110);
    step();
    $display("[TB] after reset abcd=0110 -> wxyz=%b out_valid=%b", wxyz, out_valid);
    tests++;
    if (wxyz !== 4'b0101) begin
      failed++;
      $display("FAIL postreset_wxyz: got %b expected 0101", wxyz);
    end
    tests++;
    if (out_valid !== 1'b1) begin
      failed++;
      $display("FAIL postreset_out_valid: got %b expected 1", out_valid);
    end
    drive(1'b0, 4'b0000);
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fault();
    // Word 0000 encodes to 0000, so the checker should decode 0000; forcing
    // 0001 is the same as inverting decoded bit 0.
    drive(1'b1, 4'b0000);
    step();
    tests++;
    if (rt_err !== 1'b0) begin
      failed++;
      $display("FAIL fault_pre rt_err: got %b expected 0", rt_err);
    end
    force dut.rt_decoded = 4'b0001;
    drive(1'b0, 4'b0000);
    step();
    release dut.rt_decoded;
    $display("[TB] fault injected: rt_err=%b", rt_err);
    tests++;
    if (rt_err !== 1'b1) begin
      failed++;
      $display("FAIL fault_set rt_err: got %b expected 1", rt_err);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (rt_err !== 1'b1) begin
        failed++;
        $display("FAIL fault_sticky cycle %0d: got %b expected 1", i, rt_err);
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    $display("[TB] fault cleared by reset: rt_err=%b", rt_err);
    tests++;
    if (rt_err !== 1'b0) begin
      failed++;
      $display("FAIL fault_clear rt_err: got %b expected 0", rt_err);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'b0000);
    #1;
    test_reset();
    test_single();
    test_sweep();
    test_hold();
    test_midstream_reset();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Safety net: the sequence above is fixed-length, but never let it hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/binary_to_gray.md
Name: binary_to_gray

Overview:
4-bit binary-to-Gray-code converter with a registered output stage. It accepts one 4-bit binary word per clock (a = MSB, d = LSB) and presents the reflected Gray code on w/x/y/z (w = MSB) one cycle later. It sits as a leaf utility block in front of counters/encoders that need single-bit-change codes. An internal round-trip check decodes the produced Gray word back to binary and flags any mismatch.

Parameters:
none; data width is fixed at 4 bits (constant GRAY_W = 4 in the shared package)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  input word a/b/c/d is valid this cycle
a  input  1  binary bit 3 (MSB)
b  input  1  binary bit 2
c  input  1  binary bit 1
d  input  1  binary bit 0 (LSB)
out_valid  output  1  w/x/y/z hold a freshly converted word
w  output  1  Gray bit 3 (MSB)
x  output  1  Gray bit 2
y  output  1  Gray bit 1
z  output  1  Gray bit 0 (LSB)
rt_err  output  1  round-trip check failure (sticky)

Behaviour:
- Conversion: w = a; x = a ^ b; y = b ^ c; z = c ^ d (standard reflected Gray code).
- All state updates on the rising edge of clk only; no combinational path from inputs to outputs.
- Reset: when rst_n = 0 at a rising edge, w/x/y/z <= 0, out_valid <= 0, rt_err <= 0. Reset has priority over in_valid. A reset asserted mid-stream discards any word presented in that cycle.
- Latency: exactly 1 cycle. Word presented with in_valid = 1 at edge N appears on w/x/y/z with out_valid = 1 after edge N.
- in_valid = 0: w/x/y/z hold their previous value; out_valid <= 0 at that edge.
- Back-to-back: one word per cycle, no stalls and no backpressure. out_valid mirrors in_valid delayed by one cycle.
- Round-trip check:
  - Each registered Gray word is decoded back to binary (b3 = g3; bi = b(i+1) ^ gi).
  - The decoded value is compared with a registered copy of the original binary input.
  - On mismatch while out_valid = 1, rt_err <= 1 at the next edge. rt_err stays set until reset.
  - In a correct implementation rt_err never asserts; it exists for bring-up and fault injection.
- Boundary values: 0000 -> 0000; 1111 -> 1000; wrap from 1111 to 0000 changes only the MSB (1000 -> 0000).
- X-handling: inputs are ignored while in_valid = 0; outputs must never go X after reset.

Decomposition:
- Shared package holds:
  - GRAY_W = 4;
  - pure functions bin2gray(4-bit) and gray2bin(4-bit), reused by other blocks.
- One sub-module, gray_to_binary (combinational, 4-bit), instantiated for the round-trip checker. The top module owns all registers.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1, abcd = 1111 -> w/x/y/z = 0000, out_valid = 0, rt_err = 0.
- Single words, in_valid pulsed, one cycle later:
  - 0000 -> 0000
  - 0101 -> 0111
  - 1010 -> 1111
  - 1111 -> 1000
  - out_valid high exactly one cycle for each.
- Sweep: in_valid = 1, abcd counts 0000..1111 every cycle -> consecutive wxyz differ in exactly one bit, including the wrap 1000 -> 0000; out_valid continuously 1 after the first cycle; rt_err stays 0.
- Hold: present 0110 (-> 0101), then deassert in_valid for 3 cycles with abcd = 1001 -> wxyz stays 0101, out_valid = 0.
- Mid-stream reset: streaming 0011, 0100, then rst_n = 0 during 0101 -> next cycle wxyz = 0000, out_valid = 0; after release, 0110 -> 0101 with 1-cycle latency.
- Fault injection: force the checker's decoded bit 0 inverted during a valid word -> rt_err = 1 next cycle and stays 1 until rst_n = 0.
